// File: rtl/pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_gen_pkg
//  Purpose  : Shared types and helpers for the pattern generator bank.
//  Revision : 1.0 - initial release
// ============================================================================
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_e;

  // A single channel still needs a 1-bit select so the port never collapses.
  function automatic int chanWidth(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage : pattern_gen_pkg
`default_nettype wire

// File: rtl/pattern_gen_chan.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_gen_chan
//  Purpose  : One pattern channel: pattern/seed/mode/invert state, stepping
//             logic, terminal-count pulse and gated output bit.
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_gen_chan
  import pattern_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  mode_e            loadMode,
  input  logic [WIDTH-1:0] loadSeed,
  input  logic             loadInvert,
  input  logic             run,
  input  logic             gateIn,
  output logic [WIDTH-1:0] pat,
  output logic             gated,
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;

  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_seed;
  mode_e            r_mode;
  logic             r_inv;
  logic             r_tc;
  logic             r_gated;
  logic [WIDTH-1:0] w_next;
  logic             w_tcHit;

  always_comb begin
    w_next  = r_pat;
    w_tcHit = 1'b0;
    if (run) begin
      case (r_mode)
        MODE_UP: begin
          w_next  = r_pat + c_ONE;
          w_tcHit = (r_pat == c_ALL_ONES);
        end
        MODE_DOWN: begin
          w_next  = r_pat - c_ONE;
          w_tcHit = (r_pat == '0);
        end
        MODE_LFSR: begin
          w_next  = r_pat[0] ? ((r_pat >> 1) ^ TAPS) : (r_pat >> 1);
          // A stuck state (e.g. zero) must not pulse every cycle.
          w_tcHit = (w_next == r_seed) && (w_next != r_pat);
        end
        default: begin
          w_next  = r_pat;
          w_tcHit = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat   <= '0;
      r_seed  <= '0;
      r_mode  <= MODE_HOLD;
      r_inv   <= 1'b0;
      r_tc    <= 1'b0;
      r_gated <= 1'b0;
    end else begin
      r_gated <= (gateIn ^ r_inv) & r_pat[WIDTH-1];
      if (load) begin
        r_pat  <= loadSeed;
        r_seed <= loadSeed;
        r_mode <= loadMode;
        r_inv  <= loadInvert;
        r_tc   <= 1'b0;
      end else begin
        r_pat  <= w_next;
        r_tc   <= w_tcHit;
      end
    end
  end

  assign pat   = r_pat;
  assign gated = r_gated;
  assign tc    = r_tc;

endmodule : pattern_gen_chan
`default_nettype wire

// File: rtl/pattern_gen_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_gen_bank
//  Purpose  : Bank of CH pattern generators behind a valid/ready config port.
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_gen_bank
  import pattern_gen_pkg::*;
#(
  parameter  int               CH    = 4,
  parameter  int               WIDTH = 8,
  parameter  logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  localparam int               CH_W  = chanWidth(CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_seed,
  input  logic                cfg_invert,
  input  logic [CH-1:0]       run,
  input  logic [CH-1:0]       gate_in,
  output logic [CH*WIDTH-1:0] pat_out,
  output logic [CH-1:0]       gated_out,
  output logic [CH-1:0]       tc_pulse
);

  cfg_state_e       r_state;
  cfg_state_e       w_stateNext;
  logic             w_apply;
  logic [CH_W-1:0]  r_capChan;
  mode_e            r_capMode;
  logic [WIDTH-1:0] r_capSeed;
  logic             r_capInv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CFG_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      CFG_IDLE:  if (cfg_valid) w_stateNext = CFG_APPLY;
      CFG_APPLY: w_stateNext = CFG_IDLE;
      default:   w_stateNext = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == CFG_IDLE);
    w_apply   = (r_state == CFG_APPLY);
  end

  // Fields are sampled only on acceptance; later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capChan <= '0;
      r_capMode <= MODE_HOLD;
      r_capSeed <= '0;
      r_capInv  <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      r_capChan <= cfg_chan;
      r_capMode <= mode_e'(cfg_mode);
      r_capSeed <= cfg_seed;
      r_capInv  <= cfg_invert;
    end
  end

  // Out-of-range channel numbers simply match no instance.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    logic w_load;
    assign w_load = w_apply && (r_capChan == CH_W'(gi));

    pattern_gen_chan #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .load       (w_load),
      .loadMode   (r_capMode),
      .loadSeed   (r_capSeed),
      .loadInvert (r_capInv),
      .run        (run[gi]),
      .gateIn     (gate_in[gi]),
      .pat        (pat_out[gi*WIDTH +: WIDTH]),
      .gated      (gated_out[gi]),
      .tc         (tc_pulse[gi])
    );
  end : g_chan

endmodule : pattern_gen_bank
`default_nettype wire

// File: doc/pattern_gen_bank.md
Name: pattern_gen_bank

Overview:
- Parametrised bank of CH independent WIDTH-bit pattern generators. Generalises the single free-running dummy counter used in the hierarchy-optimisation experiments.
- Per-channel mode (hold/up/down/LFSR), seed load over a valid/ready config port, terminal-count pulse, and an optionally inverted gated output bit.
- Serves as the sequential stimulus source behind the next set of cross-hierarchy optimisation test wrappers.

Parameters:
- CH, 4, number of channels (>=1)
- WIDTH, 8, pattern register width (>=2)
- TAPS, 8'hB8, Galois LFSR feedback mask, WIDTH bits
- CH_W, max(1,$clog2(CH)), derived; channel-select width; not overridable

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- cfg_valid  input  1  config request
- cfg_ready  output  1  config accept
- cfg_chan  input  CH_W  target channel
- cfg_mode  input  2  0 HOLD, 1 UP, 2 DOWN, 3 LFSR
- cfg_seed  input  WIDTH  load value
- cfg_invert  input  1  gate polarity for target channel
- run  input  CH  per-channel advance enable
- gate_in  input  CH  per-channel gate input
- pat_out  output  CH*WIDTH  channel i at [i*WIDTH +: WIDTH], registered
- gated_out  output  CH  registered gated bit
- tc_pulse  output  CH  registered terminal-count pulse

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset values:
  - all pattern regs 0, modes HOLD, invert 0, stored seeds 0
  - pat_out 0, gated_out 0, tc_pulse 0
  - config FSM in IDLE, so cfg_ready = 1
- Config FSM, two states:
  - IDLE: cfg_ready=1. cfg_valid&&cfg_ready captures chan/mode/seed/invert, then goes to APPLY.
  - APPLY: cfg_ready=0, lasts exactly 1 cycle. At the end of APPLY the target channel's pattern reg, stored seed, mode and invert take the captured values. Returns to IDLE.
  - Throughput is one config per 2 cycles. cfg_valid held high is accepted on alternate cycles. Config fields are sampled only at acceptance.
  - cfg_chan >= CH: handshake completes normally; no channel state changes.
- Channel update each cycle:
  - Load (APPLY targeting this channel) has priority over run. The loaded cycle does not advance.
  - Otherwise, if run[i]=1:
    - HOLD: no change.
    - UP: p+1, wraps all-ones to 0.
    - DOWN: p-1, wraps 0 to all-ones.
    - LFSR: p[0] ? (p>>1)^TAPS : p>>1. State 0 stays 0 (lock-up is by design, not corrected).
  - run[i]=0: no change.
- tc_pulse[i] is asserted exactly in the cycle pat_out shows the post-event value:
  - UP: wrap to 0
  - DOWN: wrap to all-ones
  - LFSR: advance lands on the stored seed
  - HOLD and loads never pulse. Only 1-cycle pulses.
- gated_out[i] <= (gate_in[i] ^ invert[i]) & p[i][WIDTH-1], using the current (pre-update) pattern reg; 1-cycle latency.
- Mode change takes effect from the cycle after APPLY.
- Reset asserted mid-APPLY: the load is discarded and all state returns to reset values. Outputs go to reset values asynchronously.
- Arithmetic is modulo 2^WIDTH, with no carries between channels.

Decomposition:
- Package pattern_gen_pkg holds:
  - enum mode_e {MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LFSR} (2 bits)
  - enum cfg_state_e {CFG_IDLE, CFG_APPLY}
- Sub-module pattern_gen_chan: one channel, containing the pattern reg, seed, mode, invert, next-state logic, tc and gated regs. Instantiated CH times via generate.
- The top level holds only the config FSM, capture registers and load decode.

Test Plan:
1. Reset with CH=4, WIDTH=8 -> pat_out=0, gated_out=0, tc_pulse=0, cfg_ready=1. Assert reset mid-run -> all outputs 0 immediately.
2. Config ch1 UP seed 8'hFD, then run[1]=1 -> ch1 shows FD,FE,FF,00,01. tc_pulse[1]=1 only in the 00 cycle. Other channels stay 0.
3. Config ch0 DOWN seed 8'h01, run[0]=1 -> 01,00,FF,FE. tc_pulse[0]=1 only in the FF cycle.
4. Config ch3 LFSR seed 8'h01, TAPS B8, run[3]=1 -> 01,B8,5C,2E,17,B3. After 255 advances, returns to 01 with tc_pulse[3]=1. Seed 00 stays 00 with no tc.
5. Handshake:
   - cfg_valid held 4 cycles -> cfg_ready pattern 1,0,1,0, two configs applied.
   - Load to a running ch1 -> seed appears, with no advance that cycle.
   - Reset during APPLY -> channel remains 0/HOLD.
   - With CH=3, cfg_chan=3 -> handshake completes, no state change.
6. Config ch2 HOLD seed 8'h80 invert=1:
   - gate_in[2]=0 -> gated_out[2]=1 next cycle.
   - gate_in[2]=1 -> gated_out[2]=0.
   - Seed 8'h7F -> gated_out[2]=0 regardless of gate_in.
